// File: rtl/iter_div_pkg.sv
// ---------------------------------------------------------------------------
// iter_div_pkg
//   Definitions shared by the iterative divider and any logic that consumes
//   its flag nibble.
//   - div_state_e : control FSM encoding (IDLE, RUN, FIX, DONE)
//   - FLAG_*      : bit positions inside the {N, Z, C, V} flag nibble. These
//                   match the ALU flag ordering so the flag register can take
//                   either source without any remapping.
// ---------------------------------------------------------------------------
package iter_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned FLAG_W = 4;

endpackage : iter_div_pkg

// File: rtl/iter_div.sv
// ---------------------------------------------------------------------------
// iter_div
//   Multicycle radix-2 restoring divider, signed or unsigned. A divide takes
//   a fixed WIDTH+2 cycles from the accepting edge to the done pulse,
//   whatever the operands (special cases included).
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : synchronous active-high reset, aborts any operation
//   start      : request a divide; only looked at in IDLE or DONE
//   is_signed  : 1 = two's-complement divide, 0 = unsigned (captured w/ start)
//   a, b       : dividend / divisor (captured with start)
//   busy       : high in RUN and FIX, used to stall the pipeline
//   done       : one-cycle pulse in DONE; results valid from this cycle on
//   Quotient   : registered quotient, held until the next result is written
//   Remainder  : registered remainder, held like Quotient
//   DivFlags   : {N, Z, C, V} from the final quotient plus special cases
// ---------------------------------------------------------------------------
module iter_div
  import iter_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_signed,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  Quotient,
  output logic [WIDTH-1:0]  Remainder,
  output logic [FLAG_W-1:0] DivFlags
);

  // Counter must hold WIDTH-1; keep at least one bit for tiny widths.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  div_state_e          state_reg;
  div_state_e          state_next;
  logic [CNT_W-1:0]    cnt_reg;

  // quo_reg starts out holding the dividend magnitude; each RUN cycle shifts
  // its MSB into the partial remainder and a new quotient bit into its LSB,
  // so after WIDTH cycles it holds the unsigned quotient.
  logic [WIDTH-1:0]    rem_reg;
  logic [WIDTH-1:0]    quo_reg;
  logic [WIDTH-1:0]    div_reg;

  logic                signed_reg;
  logic                sign_a_reg;
  logic                sign_b_reg;
  logic [WIDTH-1:0]    a_orig_reg;
  logic                div_zero_reg;
  logic                ovf_reg;

  logic [WIDTH-1:0]    quotient_reg;
  logic [WIDTH-1:0]    remainder_reg;
  logic [FLAG_W-1:0]   flags_reg;

  // -------------------------------------------------------------------------
  // Accept decode and operand preparation
  // -------------------------------------------------------------------------
  logic                accept;
  logic [WIDTH-1:0]    mag_a;
  logic [WIDTH-1:0]    mag_b;

  assign accept = start && ((state_reg == IDLE) || (state_reg == DONE));

  // The magnitude of the most-negative value is itself when read as
  // unsigned, which is exactly what the unsigned core needs.
  assign mag_a = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign mag_b = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // -------------------------------------------------------------------------
  // One restoring step
  // -------------------------------------------------------------------------
  logic [WIDTH:0]      shift_rem;
  logic [WIDTH:0]      trial;
  logic                trial_ok;
  logic [WIDTH-1:0]    rem_step;
  logic [WIDTH-1:0]    quo_step;

  always_comb begin
    shift_rem = {rem_reg, quo_reg[WIDTH-1]};
    // WIDTH+1 bit subtract: the top bit is the borrow, so a clear top bit
    // means the shifted remainder is at least the divisor.
    trial     = shift_rem - {1'b0, div_reg};
    trial_ok  = ~trial[WIDTH];
    // The remainder is always below the divisor before the shift, so the
    // kept value always fits back into WIDTH bits.
    rem_step  = trial_ok ? trial[WIDTH-1:0] : shift_rem[WIDTH-1:0];
    quo_step  = {quo_reg[WIDTH-2:0], trial_ok};
  end

  // -------------------------------------------------------------------------
  // Sign fix-up, special cases and flags (consumed in FIX)
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0]    q_fixed;
  logic [WIDTH-1:0]    r_fixed;
  logic [WIDTH-1:0]    q_final;
  logic [WIDTH-1:0]    r_final;
  logic [FLAG_W-1:0]   flags_final;

  always_comb begin
    q_fixed = quo_reg;
    r_fixed = rem_reg;
    if (signed_reg) begin
      // Truncating division: quotient negative when signs differ,
      // remainder follows the dividend.
      if (sign_a_reg ^ sign_b_reg) begin
        q_fixed = ~quo_reg + 1'b1;
      end
      if (sign_a_reg) begin
        r_fixed = ~rem_reg + 1'b1;
      end
    end

    q_final     = q_fixed;
    r_final     = r_fixed;
    flags_final = '0;

    // The iteration still ran for these; its result is simply dropped so the
    // latency never depends on operand values.
    if (div_zero_reg) begin
      q_final             = ALL_ONES;
      r_final             = a_orig_reg;
      flags_final[FLAG_C] = 1'b1;
    end else if (ovf_reg) begin
      q_final             = MOST_NEG;
      r_final             = '0;
      flags_final[FLAG_V] = 1'b1;
    end

    flags_final[FLAG_N] = q_final[WIDTH-1];
    flags_final[FLAG_Z] = (q_final == '0);
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt_reg == '0) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = DONE;
      end
      DONE: begin
        state_next = start ? RUN : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        cnt_reg <= CNT_W'(WIDTH - 1);
      end else if ((state_reg == RUN) && (cnt_reg != '0)) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_reg      <= '0;
      quo_reg      <= '0;
      div_reg      <= '0;
      signed_reg   <= 1'b0;
      sign_a_reg   <= 1'b0;
      sign_b_reg   <= 1'b0;
      a_orig_reg   <= '0;
      div_zero_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else if (accept) begin
      rem_reg      <= '0;
      quo_reg      <= mag_a;
      div_reg      <= mag_b;
      signed_reg   <= is_signed;
      sign_a_reg   <= a[WIDTH-1];
      sign_b_reg   <= b[WIDTH-1];
      a_orig_reg   <= a;
      div_zero_reg <= (b == '0);
      ovf_reg      <= is_signed && (a == MOST_NEG) && (b == ALL_ONES);
    end else if (state_reg == RUN) begin
      rem_reg      <= rem_step;
      quo_reg      <= quo_step;
    end
  end

  // Architectural results change only on the FIX -> DONE edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      quotient_reg  <= '0;
      remainder_reg <= '0;
      flags_reg     <= '0;
    end else if (state_reg == FIX) begin
      quotient_reg  <= q_final;
      remainder_reg <= r_final;
      flags_reg     <= flags_final;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy      = (state_reg == RUN) || (state_reg == FIX);
  assign done      = (state_reg == DONE);
  assign Quotient  = quotient_reg;
  assign Remainder = remainder_reg;
  assign DivFlags  = flags_reg;

endmodule : iter_div

// File: tb/tb_iter_div.sv
// ---------------------------------------------------------------------------
// tb_iter_div
//   Directed bench for iter_div at WIDTH=32. Inputs change on the falling
//   edge, outputs are sampled on the falling edge. Cycle numbering: the
//   cycle in which start is sampled is cycle 0, so done is due in cycle 34.
// ---------------------------------------------------------------------------
module tb_iter_div;

  localparam int WIDTH   = 32;
  localparam int DONE_CY = WIDTH + 2;

  logic              clk;
  logic              reset;
  logic              start;
  logic              is_signed;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  Quotient;
  logic [WIDTH-1:0]  Remainder;
  logic [3:0]        DivFlags;

  int errors = 0;
  int checks = 0;

  iter_div #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivFlags  (DivFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete divide; watches busy/done for 40 cycles after acceptance.
  task automatic do_div(input string tag, input logic sg,
                        input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic [3:0] ef);
    int done_cnt;
    int done_cyc;
    int busy_bad;
    logic [31:0] q_cap;
    logic [31:0] r_cap;
    logic [3:0]  f_cap;
    done_cnt = 0;
    done_cyc = 0;
    busy_bad = 0;
    q_cap = 'x;
    r_cap = 'x;
    f_cap = 'x;
    @(negedge clk);
    a = aa; b = bb; is_signed = sg; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (busy !== ((cyc >= 1) && (cyc <= WIDTH + 1))) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = cyc;
          q_cap = Quotient;
          r_cap = Remainder;
          f_cap = DivFlags;
        end
      end
    end
    check({tag, " done_cycle"}, done_cyc, DONE_CY);
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " busy_pattern"}, busy_bad, 0);
    check({tag, " quotient"}, q_cap, eq);
    check({tag, " remainder"}, r_cap, er);
    check({tag, " flags"}, {28'd0, f_cap}, {28'd0, ef});
    $display("op %s: a=%h b=%h s=%0d -> q=%h r=%h f=%b done@%0d",
             tag, aa, bb, sg, q_cap, r_cap, f_cap, done_cyc);
  endtask

  initial begin
    int done_cnt;
    int done_bad;
    int busy_bad;
    int hold_bad;
    logic [31:0] q1, r1, q2, r2;
    logic [3:0]  f1, f2;

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset busy", {31'd0, busy}, 0);
    check("reset done", {31'd0, done}, 0);
    check("reset quotient", Quotient, 0);
    check("reset remainder", Remainder, 0);
    check("reset flags", {28'd0, DivFlags}, 0);
    $display("reset: busy=%0d done=%0d q=%h r=%h f=%b", busy, done, Quotient, Remainder, DivFlags);

    do_div("u100_7",   1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        4'b0000);
    do_div("s-7_2",    1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 4'b1000);
    do_div("s7_-2",    1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        4'b1000);
    do_div("s5_0",     1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        4'b1010);
    do_div("u5_0",     1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        4'b1010);
    do_div("s_ovf",    1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        4'b1001);
    do_div("u_ovfops", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 4'b0100);
    do_div("u0_5",     1'b0, 32'd0,        32'd5,        32'd0,        32'd0,        4'b0100);
    do_div("s-100_7",  1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 4'b1000);

    // Reset in cycle 10 of a divide: everything clears, no done follows.
    @(negedge clk);
    a = 32'd100; b = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset busy", {31'd0, busy}, 0);
    check("midreset done", {31'd0, done}, 0);
    check("midreset quotient", Quotient, 0);
    check("midreset remainder", Remainder, 0);
    check("midreset flags", {28'd0, DivFlags}, 0);
    done_cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("midreset no_done", done_cnt, 0);
    $display("midreset: busy=%0d q=%h done_seen=%0d", busy, Quotient, done_cnt);
    do_div("after_rst", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 4'b0000);

    // Start ignored while busy, then a back-to-back start in the DONE cycle.
    done_bad = 0; busy_bad = 0; hold_bad = 0;
    q1 = 'x; r1 = 'x; f1 = 'x; q2 = 'x; r2 = 'x; f2 = 'x;
    @(negedge clk);
    a = 32'd100; b = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      @(negedge clk);
      if (done !== ((cyc == DONE_CY) || (cyc == 2 * DONE_CY))) done_bad++;
      if (busy !== (((cyc >= 1) && (cyc <= WIDTH + 1)) ||
                    ((cyc >= DONE_CY + 1) && (cyc <= DONE_CY + WIDTH + 1)))) busy_bad++;
      if ((cyc > DONE_CY) && (cyc < 2 * DONE_CY) && (Quotient !== 32'd14)) hold_bad++;
      if (cyc == 5) begin
        a = 32'd9; b = 32'd3; start = 1'b1;
      end else if (cyc == 6) begin
        start = 1'b0;
      end else if (cyc == DONE_CY) begin
        q1 = Quotient; r1 = Remainder; f1 = DivFlags;
        a = 32'd9; b = 32'd3; is_signed = 1'b0; start = 1'b1;
      end else if (cyc == DONE_CY + 1) begin
        start = 1'b0;
      end else if (cyc == 2 * DONE_CY) begin
        q2 = Quotient; r2 = Remainder; f2 = DivFlags;
      end
    end
    check("b2b first quotient", q1, 32'd14);
    check("b2b first remainder", r1, 32'd2);
    check("b2b first flags", {28'd0, f1}, 0);
    check("b2b second quotient", q2, 32'd3);
    check("b2b second remainder", r2, 32'd0);
    check("b2b second flags", {28'd0, f2}, 0);
    check("b2b done_pattern", done_bad, 0);
    check("b2b busy_pattern", busy_bad, 0);
    check("b2b result_hold", hold_bad, 0);
    $display("b2b: first q=%h r=%h f=%b second q=%h r=%h f=%b", q1, r1, f1, q2, r2, f2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_iter_div
